game_tick_sched: RTL and testbench

GAME_TICK_SCHED -- requirements
Module: game_tick_sched

---
 rtl/game_tick_sched.sv | 134 +++++++++++++
 tb/tb_game_tick_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_sched.sv
// Frame-tick scheduler: hands one VGA frame at a time to the CPU, latches debounced
// jump presses into the next frame, and counts completed and overrun frames.
module game_tick_sched #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned OVR_W           = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             screen_end,
   input  logic             up,
   input  logic             down,
   input  logic             cpu_ack,
   output logic             frame_go,
   output logic             io_jump,
   output logic             io_duck,
   output logic [15:0]      frame_count,
   output logic [OVR_W-1:0] overrun_count,
   output logic             busy
);

   localparam int unsigned CNT_W = 20;
   localparam int unsigned FC_W  = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   // index 0 = up, index 1 = down
   logic [1:0]       sync1, sync2, db;
   logic [CNT_W-1:0] cnt [2];
   logic             up_rise_c;

   logic prev_se, armed, tick_q;

   state_t           state, state_nx;
   logic             jump_q, jump_nx;
   logic             pend_q, pend_nx;
   logic [FC_W-1:0]  fc_q, fc_nx;
   logic [OVR_W-1:0] ovr_q, ovr_nx;

   // Synchronizers and debouncers: level accepted after DEBOUNCE_CYCLES differing samples
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= {down, up};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign up_rise_c = sync2[0] & ~db[0] & (cnt[0] == CNT_LAST);

   // Tick detect; armed blocks a tick from a screen_end already high out of reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         prev_se <= 1'b0;
         armed   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         prev_se <= screen_end;
         armed   <= armed | ~screen_end;
         tick_q  <= screen_end & ~prev_se & armed;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         jump_q <= 1'b0;
         pend_q <= 1'b0;
         fc_q   <= '0;
         ovr_q  <= '0;
      end else begin
         state  <= state_nx;
         jump_q <= jump_nx;
         pend_q <= pend_nx;
         fc_q   <= fc_nx;
         ovr_q  <= ovr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      jump_nx  = jump_q;
      pend_nx  = pend_q;
      fc_nx    = fc_q;
      ovr_nx   = ovr_q;
      case (state)
         IDLE: begin
            if (tick_q) begin
               state_nx = RUN;
               jump_nx  = pend_q;
               pend_nx  = 1'b0;
            end
         end
         RUN: begin
            if (cpu_ack && tick_q) begin
               fc_nx   = fc_q + FC_W'(1);
               jump_nx = pend_q;
               pend_nx = 1'b0;
            end else if (cpu_ack) begin
               state_nx = IDLE;
               fc_nx    = fc_q + FC_W'(1);
               jump_nx  = 1'b0;
            end else if (tick_q && (ovr_q != '1)) begin
               ovr_nx = ovr_q + OVR_W'(1);
            end
         end
      endcase
      // a press landing on the consuming cycle survives into the next frame
      if (up_rise_c) pend_nx = 1'b1;
   end

   assign frame_go      = (state == RUN);
   assign busy          = frame_go;
   assign io_jump       = jump_q;
   assign io_duck       = db[1];
   assign frame_count   = fc_q;
   assign overrun_count = ovr_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched; expected outputs queued per step, popped at sample time.
module tb_game_tick_sched;

   logic        clock, reset, screen_end, up, down, cpu_ack;
   logic        frame_go, io_jump, io_duck, busy;
   logic [15:0] frame_count;
   logic [7:0]  overrun_count;
   logic        frame_go2, io_jump2, io_duck2, busy2;
   logic [15:0] frame_count2;
   logic [1:0]  overrun_count2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic        go;
      logic        jump;
      logic        duck;
      logic [15:0] fc;
      logic [7:0]  ovr;
      logic [1:0]  ovr2;
   } exp_t;

   exp_t sb[$];

   game_tick_sched #(.DEBOUNCE_CYCLES(4), .OVR_W(8)) u_dut (
      .clock(clock), .reset(reset), .screen_end(screen_end), .up(up), .down(down),
      .cpu_ack(cpu_ack), .frame_go(frame_go), .io_jump(io_jump), .io_duck(io_duck),
      .frame_count(frame_count), .overrun_count(overrun_count), .busy(busy)
   );

   game_tick_sched #(.DEBOUNCE_CYCLES(4), .OVR_W(2)) u_dut2 (
      .clock(clock), .reset(reset), .screen_end(screen_end), .up(up), .down(down),
      .cpu_ack(cpu_ack), .frame_go(frame_go2), .io_jump(io_jump2), .io_duck(io_duck2),
      .frame_count(frame_count2), .overrun_count(overrun_count2), .busy(busy2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic go, input logic jump, input logic duck,
                             input logic [15:0] fc, input logic [7:0] ovr, input logic [1:0] ovr2);
      exp_t e;
      e.tag = tag; e.go = go; e.jump = jump; e.duck = duck;
      e.fc = fc; e.ovr = ovr; e.ovr2 = ovr2;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".frame_go"},      32'(frame_go),       32'(e.go));
      chk({e.tag, ".busy"},          32'(busy),           32'(e.go));
      chk({e.tag, ".io_jump"},       32'(io_jump),        32'(e.jump));
      chk({e.tag, ".io_duck"},       32'(io_duck),        32'(e.duck));
      chk({e.tag, ".frame_count"},   32'(frame_count),    32'(e.fc));
      chk({e.tag, ".overrun_count"}, 32'(overrun_count),  32'(e.ovr));
      chk({e.tag, ".frame_go2"},     32'(frame_go2),      32'(e.go));
      chk({e.tag, ".busy2"},         32'(busy2),          32'(e.go));
      chk({e.tag, ".io_jump2"},      32'(io_jump2),       32'(e.jump));
      chk({e.tag, ".io_duck2"},      32'(io_duck2),       32'(e.duck));
      chk({e.tag, ".frame_count2"},  32'(frame_count2),   32'(e.fc));
      chk({e.tag, ".overrun2"},      32'(overrun_count2), 32'(e.ovr2));
   endtask

   // screen_end high for one cycle; frame logic reacts one edge after the detecting edge
   task automatic tick();
      screen_end = 1'b1;
      cyc(1);
      screen_end = 1'b0;
      cyc(1);
   endtask

   task automatic ack();
      cpu_ack = 1'b1;
      cyc(1);
      cpu_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0; screen_end = 1'b0; up = 1'b0; down = 1'b0; cpu_ack = 1'b0;
      cyc(3);
      expect_out("reset", 0, 0, 0, 16'd0, 8'd0, 2'd0);
      sb_check();
      reset = 1'b1;
      cyc(2);

      // ack while idle is ignored
      ack();
      cyc(1);
      expect_out("idle_ack", 0, 0, 0, 16'd0, 8'd0, 2'd0);
      sb_check();

      // held jump press reaches the next frame
      up = 1'b1; cyc(10);
      up = 1'b0; cyc(10);
      tick();
      expect_out("jump_frame", 1, 1, 0, 16'd0, 8'd0, 2'd0);
      sb_check();
      ack();
      expect_out("jump_ack", 0, 0, 0, 16'd1, 8'd0, 2'd0);
      sb_check();

      down = 1'b1; cyc(10);
      expect_out("duck_on", 0, 0, 1, 16'd1, 8'd0, 2'd0);
      sb_check();
      down = 1'b0; cyc(10);
      expect_out("duck_off", 0, 0, 0, 16'd1, 8'd0, 2'd0);
      sb_check();

      // bouncing button never debounces
      for (int i = 0; i < 10; i++) begin
         up = 1'b1; cyc(2);
         up = 1'b0; cyc(2);
      end
      cyc(6);
      tick();
      expect_out("bounce_frame", 1, 0, 0, 16'd1, 8'd0, 2'd0);
      sb_check();
      ack();
      expect_out("bounce_ack", 0, 0, 0, 16'd2, 8'd0, 2'd0);
      sb_check();

      // overruns, including saturation of the narrow counter
      tick();
      tick(); tick(); tick();
      cyc(2);
      expect_out("overrun3", 1, 0, 0, 16'd2, 8'd3, 2'd3);
      sb_check();
      tick(); tick();
      cyc(2);
      expect_out("overrun5", 1, 0, 0, 16'd2, 8'd5, 2'd3);
      sb_check();
      ack();
      expect_out("overrun_ack", 0, 0, 0, 16'd3, 8'd5, 2'd3);
      sb_check();

      // press during a frame, then ack and tick together
      tick();
      up = 1'b1; cyc(10);
      up = 1'b0; cyc(10);
      expect_out("pend_in_run", 1, 0, 0, 16'd3, 8'd5, 2'd3);
      sb_check();
      screen_end = 1'b1;
      cyc(1);
      screen_end = 1'b0;
      cpu_ack = 1'b1;
      cyc(1);
      cpu_ack = 1'b0;
      expect_out("ack_tick", 1, 1, 0, 16'd4, 8'd5, 2'd3);
      sb_check();
      cyc(1);
      expect_out("ack_tick_hold", 1, 1, 0, 16'd4, 8'd5, 2'd3);
      sb_check();
      ack();
      expect_out("ack_after", 0, 0, 0, 16'd5, 8'd5, 2'd3);
      sb_check();

      // reset mid-frame with screen_end held high
      tick();
      screen_end = 1'b1;
      cyc(2);
      expect_out("pre_reset", 1, 0, 0, 16'd5, 8'd6, 2'd3);
      sb_check();
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      expect_out("mid_reset", 0, 0, 0, 16'd0, 8'd0, 2'd0);
      sb_check();
      cyc(5);
      expect_out("held_high", 0, 0, 0, 16'd0, 8'd0, 2'd0);
      sb_check();
      screen_end = 1'b0;
      cyc(2);
      tick();
      expect_out("rearmed", 1, 0, 0, 16'd0, 8'd0, 2'd0);
      sb_check();
      ack();
      expect_out("rearmed_ack", 0, 0, 0, 16'd1, 8'd0, 2'd0);
      sb_check();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
